// File: rtl/fw_status_collector.sv
// Firmware status collector: live uptime, sticky error flags, error-event count and cycle count,
// handed to the register block as an atomic four-word snapshot over a req/valid/ack handshake.
module fw_status_collector #(
    parameter int unsigned CLK_FREQ_HZ = 100000000,
    parameter int unsigned N_ERR       = 8,
    parameter logic [31:0] FW_VERSION  = 32'h00010000
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic [N_ERR-1:0] err_in,
    input  logic             err_clr,
    input  logic [N_ERR-1:0] err_clr_mask,
    input  logic             snap_req,
    input  logic             snap_ack,
    output logic             snap_valid,
    output logic [31:0]      status_word0,
    output logic [31:0]      status_word1,
    output logic [31:0]      status_word2,
    output logic [31:0]      status_word3,
    output logic             heartbeat
);

    localparam logic [31:0] PRESC_MAX = 32'(CLK_FREQ_HZ - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        presc_q, presc_d;
    logic [31:0]        uptime_q, uptime_d;
    logic               heartbeat_q, heartbeat_d;
    logic [31:0]        cycle_q, cycle_d;
    logic [N_ERR-1:0]   sticky_q, sticky_d;
    logic [N_ERR-1:0]   err_in_d_q, err_in_d_d;
    logic [15:0]        err_count_q, err_count_d;
    logic               snap_valid_q, snap_valid_d;
    logic [31:0]        word0_q, word0_d;
    logic [31:0]        word1_q, word1_d;
    logic [31:0]        word2_q, word2_d;
    logic [31:0]        word3_q, word3_d;

    // word2 layout: count in the top half, sticky flags in the low bits, zero between
    function automatic logic [31:0] pack_word2(input logic [15:0] cnt, input logic [N_ERR-1:0] st);
        logic [31:0] w;
        w              = 32'h0000_0000;
        w[31:16]       = cnt;
        w[N_ERR-1:0]   = st;
        return w;
    endfunction

    // Live counters: prescaler/uptime/heartbeat, cycle counter, sticky flags, error-event count
    always_comb begin
        presc_d     = presc_q + 32'd1;
        uptime_d    = uptime_q;
        heartbeat_d = heartbeat_q;
        if (presc_q == PRESC_MAX) begin
            presc_d     = 32'd0;
            uptime_d    = uptime_q + 32'd1;
            heartbeat_d = ~heartbeat_q;
        end else begin
            presc_d     = presc_q + 32'd1;
        end
        cycle_d    = cycle_q + 32'd1;
        sticky_d   = (sticky_q & ~({N_ERR{err_clr}} & err_clr_mask)) | err_in;
        err_in_d_d = err_in;
        if ((|(err_in & ~err_in_d_q)) && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Snapshot FSM: capture pre-update live values on request, freeze until acknowledged
    always_comb begin
        state_d      = state_q;
        snap_valid_d = snap_valid_q;
        word0_d      = word0_q;
        word1_d      = word1_q;
        word2_d      = word2_q;
        word3_d      = word3_q;
        case (state_q)
            ST_IDLE: begin
                if (snap_req) begin
                    state_d      = ST_HOLD;
                    snap_valid_d = 1'b1;
                    word0_d      = FW_VERSION;
                    word1_d      = uptime_q;
                    word2_d      = pack_word2(err_count_q, sticky_q);
                    word3_d      = cycle_q;
                end else begin
                    state_d      = ST_IDLE;
                end
            end
            ST_HOLD: begin
                // an ack always wins over a concurrent request; recapture needs IDLE first
                if (snap_ack) begin
                    state_d      = ST_IDLE;
                    snap_valid_d = 1'b0;
                end else begin
                    state_d      = ST_HOLD;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                snap_valid_d = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q      <= ST_IDLE;
            presc_q      <= 32'd0;
            uptime_q     <= 32'd0;
            heartbeat_q  <= 1'b0;
            cycle_q      <= 32'd0;
            sticky_q     <= '0;
            err_in_d_q   <= '0;
            err_count_q  <= 16'd0;
            snap_valid_q <= 1'b0;
            word0_q      <= 32'd0;
            word1_q      <= 32'd0;
            word2_q      <= 32'd0;
            word3_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            uptime_q     <= uptime_d;
            heartbeat_q  <= heartbeat_d;
            cycle_q      <= cycle_d;
            sticky_q     <= sticky_d;
            err_in_d_q   <= err_in_d_d;
            err_count_q  <= err_count_d;
            snap_valid_q <= snap_valid_d;
            word0_q      <= word0_d;
            word1_q      <= word1_d;
            word2_q      <= word2_d;
            word3_q      <= word3_d;
        end
    end

    assign snap_valid   = snap_valid_q;
    assign status_word0 = word0_q;
    assign status_word1 = word1_q;
    assign status_word2 = word2_q;
    assign status_word3 = word3_q;
    assign heartbeat    = heartbeat_q;

endmodule

// File: tb/tb_fw_status_collector.sv
// Self-checking bench for fw_status_collector: table-driven sticky/count vectors plus
// hand-written sequences for uptime, saturation, handshake freeze and reset mid-hold.
module tb_fw_status_collector;

    logic        ACLK;
    logic        ARESET;
    logic [7:0]  err_in;
    logic        err_clr;
    logic [7:0]  err_clr_mask;
    logic        snap_req;
    logic        snap_ack;
    logic        snap_valid;
    logic [31:0] status_word0, status_word1, status_word2, status_word3;
    logic        heartbeat;

    int errors = 0;
    int checks = 0;

    fw_status_collector #(
        .CLK_FREQ_HZ(10),
        .N_ERR(8),
        .FW_VERSION(32'h00010000)
    ) dut (
        .ACLK(ACLK),
        .ARESET(ARESET),
        .err_in(err_in),
        .err_clr(err_clr),
        .err_clr_mask(err_clr_mask),
        .snap_req(snap_req),
        .snap_ack(snap_ack),
        .snap_valid(snap_valid),
        .status_word0(status_word0),
        .status_word1(status_word1),
        .status_word2(status_word2),
        .status_word3(status_word3),
        .heartbeat(heartbeat)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    typedef struct {
        logic [7:0]  ein;
        logic        clr;
        logic [7:0]  mask;
        logic        req;
        logic        ack;
        logic        exp_valid;
        logic        chk_w2;
        logic [31:0] exp_w2;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t mk(input logic [7:0] ein, input logic clr, input logic [7:0] mask,
                                input logic req, input logic ack, input logic ev,
                                input logic cw, input logic [31:0] ew);
        vec_t v;
        v.ein = ein; v.clr = clr; v.mask = mask; v.req = req; v.ack = ack;
        v.exp_valid = ev; v.chk_w2 = cw; v.exp_w2 = ew;
        return v;
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic snap();
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
    endtask

    task automatic release_snap();
        snap_ack = 1'b1;
        tick();
        snap_ack = 1'b0;
    endtask

    task automatic reset_pulse();
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
    endtask

    initial begin
        ARESET = 1'b1; err_in = 8'h00; err_clr = 1'b0; err_clr_mask = 8'h00;
        snap_req = 1'b0; snap_ack = 1'b0;

        // ---- reset state and uptime/heartbeat ----
        for (int i = 0; i < 10; i++) tick();
        chk("rst_valid", {31'd0, snap_valid}, 32'd0);
        chk("rst_hb", {31'd0, heartbeat}, 32'd0);
        chk("rst_w0", status_word0, 32'd0);
        chk("rst_w1", status_word1, 32'd0);
        chk("rst_w2", status_word2, 32'd0);
        chk("rst_w3", status_word3, 32'd0);
        ARESET = 1'b0;
        for (int i = 1; i <= 35; i++) begin
            tick();
            chk("hb_toggle", {31'd0, heartbeat}, ((i / 10) % 2 == 1) ? 32'd1 : 32'd0);
        end
        snap();
        chk("up_valid", {31'd0, snap_valid}, 32'd1);
        chk("up_w0", status_word0, 32'h00010000);
        chk("up_w1", status_word1, 32'd3);
        chk("up_w2", status_word2, 32'd0);
        chk("up_w3", status_word3, 32'd35);
        release_snap();
        chk("up_rel_valid", {31'd0, snap_valid}, 32'd0);
        chk("up_keep_w1", status_word1, 32'd3);

        // ---- table: sticky set/clear collision, clr gating, edge counting ----
        vecs[0]  = mk(8'h04, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs[1]  = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs[2]  = mk(8'h04, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs[3]  = mk(8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00020004);
        vecs[4]  = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00020004);
        vecs[5]  = mk(8'h00, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs[6]  = mk(8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00020000);
        vecs[7]  = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        vecs[8]  = mk(8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs[9]  = mk(8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs[10] = mk(8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00030001);
        vecs[11] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        vecs[12] = mk(8'h03, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        vecs[13] = mk(8'h03, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00040003);
        vecs[14] = mk(8'h03, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        vecs[15] = mk(8'h03, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00040003);
        vecs[16] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 17; i++) begin
            err_in = vecs[i].ein; err_clr = vecs[i].clr; err_clr_mask = vecs[i].mask;
            snap_req = vecs[i].req; snap_ack = vecs[i].ack;
            tick();
            chk($sformatf("vec%0d_valid", i), {31'd0, snap_valid}, {31'd0, vecs[i].exp_valid});
            if (vecs[i].chk_w2) chk($sformatf("vec%0d_w2", i), status_word2, vecs[i].exp_w2);
        end
        err_clr = 1'b0; err_clr_mask = 8'h00; snap_req = 1'b0; snap_ack = 1'b0;

        // ---- err_count: simultaneous edges, level hold, saturation ----
        reset_pulse();
        err_in = 8'h03;
        for (int i = 0; i < 6; i++) tick();
        snap();
        chk("cnt_multi_edge", status_word2, 32'h00010003);
        release_snap();
        for (int i = 0; i < 65540; i++) begin
            err_in = (i % 2 == 0) ? 8'hF0 : 8'h0F;
            tick();
        end
        snap();
        chk("cnt_saturate", status_word2, 32'hFFFF00FF);
        release_snap();
        err_in = 8'h00; err_clr = 1'b1; err_clr_mask = 8'hFF;
        tick();
        err_clr = 1'b0; err_clr_mask = 8'h00;
        snap();
        chk("cnt_survives_clr", status_word2, 32'hFFFF0000);
        release_snap();

        // ---- handshake freeze, ack release, req+ack collision ----
        reset_pulse();
        for (int i = 0; i < 4; i++) tick();
        snap();
        chk("hold_w3", status_word3, 32'd4);
        err_in = 8'h81;
        for (int i = 0; i < 20; i++) begin
            snap_req = (i % 3 == 1);
            tick();
            chk("hold_valid", {31'd0, snap_valid}, 32'd1);
            chk("hold_frozen_w3", status_word3, 32'd4);
            chk("hold_frozen_w2", status_word2, 32'd0);
        end
        snap_req = 1'b0;
        release_snap();
        chk("ack_valid", {31'd0, snap_valid}, 32'd0);
        chk("ack_keep_w3", status_word3, 32'd4);
        snap();
        chk("fresh_w1", status_word1, 32'd2);
        chk("fresh_w2", status_word2, 32'h00010081);
        chk("fresh_w3", status_word3, 32'd26);
        snap_req = 1'b1; snap_ack = 1'b1;
        tick();
        snap_ack = 1'b0;
        chk("reqack_valid", {31'd0, snap_valid}, 32'd0);
        chk("reqack_nocap_w3", status_word3, 32'd26);
        tick();
        snap_req = 1'b0;
        chk("recap_valid", {31'd0, snap_valid}, 32'd1);
        chk("recap_w3", status_word3, 32'd28);

        // ---- reset while holding a snapshot ----
        err_in = 8'h00;
        reset_pulse();
        chk("midrst_valid", {31'd0, snap_valid}, 32'd0);
        chk("midrst_w0", status_word0, 32'd0);
        chk("midrst_w1", status_word1, 32'd0);
        chk("midrst_w2", status_word2, 32'd0);
        chk("midrst_w3", status_word3, 32'd0);
        chk("midrst_hb", {31'd0, heartbeat}, 32'd0);
        for (int i = 0; i < 12; i++) tick();
        snap();
        chk("postrst_w1", status_word1, 32'd1);
        chk("postrst_w3", status_word3, 32'd12);
        release_snap();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
